// File: rtl/parity_pkg.sv
// rtl/parity_pkg.sv - shared constants and state type for the parity stream block
package parity_pkg;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;
    localparam logic MODE_GEN = 1'b0;
    localparam logic MODE_CHK = 1'b1;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } ostate_t;

endpackage

// File: rtl/parity_tree.sv
// rtl/parity_tree.sv - combinational XOR reduction of a payload word
module parity_tree #(
    parameter int N = 8
) (
    input  logic [N-1:0] payload,
    output logic         parity
);

    assign parity = ^payload;

endmodule

// File: rtl/parity_stream.sv
// rtl/parity_stream.sv - registered valid/ready parity generator/checker with error accounting
module parity_stream
    import parity_pkg::*;
#(
    parameter int N     = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode_odd,
    input  logic             chk_en,
    input  logic             clr_err,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N:0]       in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N:0]       out_data,
    output logic             out_err,
    output logic [CNT_W-1:0] err_count,
    output logic             err_sticky
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    ostate_t state;
    logic    tree_p;
    logic    exp_p;
    logic    mismatch;
    logic    accept;
    logic    deliver;

    parity_tree #(.N(N)) u_tree (
        .payload (in_data[N:1]),
        .parity  (tree_p)
    );

    assign exp_p     = tree_p ^ (mode_odd == PAR_ODD);
    assign mismatch  = (chk_en == MODE_CHK) && (in_data[0] != exp_p);
    assign out_valid = (state == ST_FULL);
    // Ready is withheld during reset so no word slips in while the stage is being cleared.
    assign in_ready  = !rst && ((state == ST_EMPTY) || out_ready);
    assign accept    = in_valid && in_ready;
    assign deliver   = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_EMPTY;
            out_data   <= '0;
            out_err    <= 1'b0;
            err_count  <= '0;
            err_sticky <= 1'b0;
        end else begin
            case (state)
                ST_EMPTY: if (accept) state <= ST_FULL;
                ST_FULL:  if (deliver && !accept) state <= ST_EMPTY;
                default:  state <= ST_EMPTY;
            endcase

            if (accept) begin
                out_data <= (chk_en == MODE_CHK) ? in_data : {in_data[N:1], exp_p};
                out_err  <= mismatch;
            end

            // Clear wins over a coincident mismatched acceptance.
            if (clr_err) begin
                err_count  <= '0;
                err_sticky <= 1'b0;
            end else if (accept && mismatch) begin
                err_sticky <= 1'b1;
                if (err_count != CNT_MAX) err_count <= err_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_parity_stream.sv
// tb/tb_parity_stream.sv - directed self-checking bench for parity_stream
module tb_parity_stream;

    logic       clk = 1'b0;
    logic       rst;
    logic       mode_odd;
    logic       chk_en;
    logic       clr_err;
    logic       in_valid;
    logic [8:0] in_data;
    logic       out_ready;

    logic        in_ready, out_valid, out_err, err_sticky;
    logic [8:0]  out_data;
    logic [15:0] err_count;

    logic        sat_in_ready, sat_out_valid, sat_out_err, sat_err_sticky;
    logic [8:0]  sat_out_data;
    logic [1:0]  sat_err_count;

    logic        n1_in_ready, n1_out_valid, n1_out_err, n1_err_sticky;
    logic [1:0]  n1_out_data;
    logic [15:0] n1_err_count;

    int checks = 0;
    int errors = 0;
    int acc_cnt = 0;
    int dlv_cnt = 0;
    logic [9:0] sb_q[$];

    always #5 clk = ~clk;

    parity_stream #(.N(8), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .mode_odd(mode_odd), .chk_en(chk_en), .clr_err(clr_err),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err),
        .err_count(err_count), .err_sticky(err_sticky)
    );

    parity_stream #(.N(8), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .mode_odd(mode_odd), .chk_en(chk_en), .clr_err(clr_err),
        .in_valid(in_valid), .in_ready(sat_in_ready), .in_data(in_data),
        .out_valid(sat_out_valid), .out_ready(out_ready), .out_data(sat_out_data), .out_err(sat_out_err),
        .err_count(sat_err_count), .err_sticky(sat_err_sticky)
    );

    parity_stream #(.N(1), .CNT_W(16)) u_n1 (
        .clk(clk), .rst(rst), .mode_odd(mode_odd), .chk_en(chk_en), .clr_err(clr_err),
        .in_valid(in_valid), .in_ready(n1_in_ready), .in_data(in_data[1:0]),
        .out_valid(n1_out_valid), .out_ready(out_ready), .out_data(n1_out_data), .out_err(n1_out_err),
        .err_count(n1_err_count), .err_sticky(n1_err_sticky)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [9:0] model(input logic [8:0] d, input logic chk, input logic odd);
        logic p;
        p = (^d[8:1]) ^ odd;
        if (chk) model = {d[0] != p, d};
        else     model = {1'b0, d[8:1], p};
    endfunction

    // Scoreboard samples 1 time unit before each rising edge.
    always @(negedge clk) begin
        #4;
        if (rst) begin
            sb_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                dlv_cnt++;
                if (sb_q.size() == 0) check("dlv_spurious", 1, 0);
                else check("dlv_word", {22'd0, out_err, out_data}, {22'd0, sb_q.pop_front()});
            end
            if (in_valid && in_ready) begin
                acc_cnt++;
                sb_q.push_back(model(in_data, chk_en, mode_odd));
            end
        end
    end

    initial begin
        int a0, d0, cyc;
        rst = 1'b1; mode_odd = 1'b0; chk_en = 1'b0; clr_err = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

        #2;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_err", out_err, 0);
        check("rst_err_count", err_count, 0);
        check("rst_err_sticky", err_sticky, 0);
        check("rst_in_ready", in_ready, 0);

        // generate even A5, accepted on first edge after reset release
        @(negedge clk);
        rst = 1'b0; out_ready = 1'b1; in_valid = 1'b1;
        in_data = {8'hA5, 1'b0}; chk_en = 1'b0; mode_odd = 1'b0;
        @(negedge clk);
        check("gen_even_valid", out_valid, 1);
        check("gen_even_data", out_data, 9'h14A);
        check("gen_even_err", out_err, 0);
        check("n1_gen_even_data", n1_out_data, 2'b11);

        in_data = {8'h01, 1'b0}; mode_odd = 1'b1;
        @(negedge clk);
        check("gen_odd_data", out_data, 9'h002);
        check("gen_odd_err", out_err, 0);

        in_data = 9'h002; chk_en = 1'b1; mode_odd = 1'b0;
        @(negedge clk);
        check("chk_even_data", out_data, 9'h002);
        check("chk_even_err", out_err, 1);
        check("chk_even_count", err_count, 1);
        check("chk_even_sticky", err_sticky, 1);

        in_valid = 1'b0;
        @(negedge clk);
        check("drained_valid", out_valid, 0);

        // backpressure
        out_ready = 1'b0; in_valid = 1'b1; chk_en = 1'b0; mode_odd = 1'b0;
        in_data = {8'h3C, 1'b0};
        a0 = acc_cnt;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 0) in_data = 9'h1FF;
            check("bp_data", out_data, 9'h078);
            check("bp_in_ready", in_ready, 0);
        end
        check("bp_accepts", acc_cnt - a0, 1);
        check("bp_sticky_held", err_sticky, 1);

        // 100-word random stream at full rate
        out_ready = 1'b1;
        a0 = acc_cnt; cyc = 0;
        while ((acc_cnt - a0) < 100 && cyc < 300) begin
            in_data = 9'($urandom);
            chk_en = 1'($urandom);
            mode_odd = 1'($urandom);
            @(negedge clk);
            cyc++;
        end
        check("stream_cycles", cyc, 100);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("stream_queue_empty", sb_q.size(), 0);
        check("stream_dlv_eq_acc", dlv_cnt, acc_cnt);
        check("stream_idle_valid", out_valid, 0);

        // saturation on CNT_W = 2
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        check("sat_cleared", sat_err_count, 0);
        chk_en = 1'b1; mode_odd = 1'b0; in_data = 9'h002; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("sat_count", sat_err_count, (i < 3) ? i + 1 : 3);
        end
        check("sat_sticky", sat_err_sticky, 1);
        check("n1_bad_count", n1_err_count, 5);
        clr_err = 1'b1;
        @(negedge clk);
        check("clr_prio_sat_count", sat_err_count, 0);
        check("clr_prio_sat_sticky", sat_err_sticky, 0);
        check("clr_prio_count", err_count, 0);
        check("clr_prio_sticky", err_sticky, 0);
        check("clr_keeps_valid", out_valid, 1);
        check("clr_keeps_err", out_err, 1);
        clr_err = 1'b0; in_valid = 1'b0;
        repeat (2) @(negedge clk);

        // reset while holding a word
        out_ready = 1'b0; in_valid = 1'b1; chk_en = 1'b1; in_data = 9'h002;
        @(negedge clk);
        in_valid = 1'b0;
        check("pre_rst_valid", out_valid, 1);
        check("pre_rst_count", err_count, 1);
        d0 = dlv_cnt;
        #2 rst = 1'b1;
        #1;
        check("async_rst_valid", out_valid, 0);
        check("async_rst_data", out_data, 0);
        check("async_rst_count", err_count, 0);
        check("async_rst_sticky", err_sticky, 0);
        check("async_rst_ready", in_ready, 0);
        @(negedge clk);
        rst = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("held_word_dropped", dlv_cnt - d0, 0);
        check("post_rst_valid", out_valid, 0);

        // mode toggling every word
        a0 = acc_cnt;
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_data = 9'($urandom);
            chk_en = 1'(i % 2);
            mode_odd = 1'((i + 1) % 2);
            @(negedge clk);
        end
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("mode_accepts", acc_cnt - a0, 20);
        check("mode_queue_empty", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
